// File: rtl/rpm_poll_pkg.sv
// Shared types and constants for the RPM poll sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rpm_poll_pkg;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int   RPM_W        = 16;
    localparam int   AVALON_DW    = 32;
    // Every RPM slave exposes its speed register at word address 0
    localparam logic RPM_REG_ADDR = 1'b0;

endpackage

// File: rtl/rpm_poll_sequencer_period_tick_gen.sv
// Free-running period counter producing one sweep-start tick every PERIOD cycles.
// Latency: tick is combinational from the registered count (asserted while count==PERIOD-1).
// Backpressure: none; enable low parks the count at 0 and suppresses ticks.
module period_tick_gen #(
    parameter int PERIOD = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick
);

    localparam int CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    logic [CNT_W-1:0] count;

    // Count 0..PERIOD-1 while enabled, wrap at the end, hold at 0 when disabled
    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = enable && (count == LAST);

endmodule

// File: rtl/rpm_poll_sequencer.sv
// Avalon-MM read master sweeping NUM_CH RPM slaves once per period and publishing the readings.
// Latency: first read one cycle after tick; sample_valid one cycle after the last channel completes.
// Backpressure: honours m_waitrequest per read, aborting after TIMEOUT wait cycles; ticks during a sweep are dropped and flagged.
module rpm_poll_sequencer
    import rpm_poll_pkg::*;
#(
    parameter int NUM_CH  = 4,
    parameter int PERIOD  = 50000,
    parameter int TIMEOUT = 15
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      clear_err,
    output logic [NUM_CH-1:0]         m_chipselect,
    output logic                      m_address,
    output logic                      m_read,
    input  logic [AVALON_DW-1:0]      m_readdata,
    input  logic                      m_waitrequest,
    output logic [RPM_W*NUM_CH-1:0]   rpm_flat,
    output logic                      sample_valid,
    output logic [NUM_CH-1:0]         timeout_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT);

    state_t               state;
    logic [CH_W-1:0]      ch;
    logic [WAIT_W-1:0]    wait_cnt;
    logic [RPM_W-1:0]     rpm_q [NUM_CH];
    logic                 tick;
    logic                 rd_done;
    logic                 rd_abort;
    logic [NUM_CH-1:0]    err_set;
    logic                 unused_readdata_hi;

    // Upper half of the slave word carries no speed information
    assign unused_readdata_hi = ^m_readdata[AVALON_DW-1:RPM_W];

    period_tick_gen #(
        .PERIOD (PERIOD)
    ) u_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .tick   (tick)
    );

    // Classify the current READ cycle as a completion, an abort, or neither
    always_comb begin
        rd_done  = (state == READ) && m_read && !m_waitrequest;
        rd_abort = (state == READ) && m_read && m_waitrequest && (wait_cnt == WAIT_LAST);
        err_set  = '0;
        if (rd_abort) begin
            err_set = NUM_CH'(1) << ch;
        end
    end

    // Sweep FSM: walks the channels, drives the Avalon master and captures readings
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            ch           <= '0;
            wait_cnt     <= '0;
            m_read       <= 1'b0;
            m_chipselect <= '0;
            m_address    <= RPM_REG_ADDR;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                rpm_q[i] <= '0;
            end
        end else begin
            m_address    <= RPM_REG_ADDR;
            sample_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (tick) begin
                        state        <= READ;
                        ch           <= '0;
                        wait_cnt     <= '0;
                        m_read       <= 1'b1;
                        m_chipselect <= NUM_CH'(1);
                        busy         <= 1'b1;
                    end
                end
                READ: begin
                    if (rd_done) begin
                        rpm_q[ch] <= m_readdata[RPM_W-1:0];
                    end
                    if (rd_done || rd_abort) begin
                        wait_cnt <= '0;
                        if (ch == LAST_CH) begin
                            state        <= DONE;
                            m_read       <= 1'b0;
                            m_chipselect <= '0;
                            sample_valid <= 1'b1;
                        end else begin
                            ch           <= ch + 1'b1;
                            m_chipselect <= m_chipselect << 1;
                        end
                    end else if (m_waitrequest) begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    m_read       <= 1'b0;
                    m_chipselect <= '0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

    // Sticky error flags; a fresh error in the clearing cycle survives the clear
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= '0;
            overrun     <= 1'b0;
        end else begin
            if (clear_err) begin
                timeout_err <= err_set;
            end else begin
                timeout_err <= timeout_err | err_set;
            end
            if (tick && (state != IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_err) begin
                overrun <= 1'b0;
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_flat
        assign rpm_flat[g*RPM_W +: RPM_W] = rpm_q[g];
    end

endmodule
